// File: rtl/ysyx_23060096_ifu.sv
// Multi-cycle instruction fetch unit: one word fetch in flight, released to decode, then held until commit.
// Optional performance counters are enabled by defining YSYX_23060096_IFU_PERF_EN.
module ysyx_23060096_ifu #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_dnpc,
    output logic            fetch_err
`ifdef YSYX_23060096_IFU_PERF_EN
   ,output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_wait_cnt
`endif
);

    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_OUT  = 3'd2,
        S_EXEC = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [ILEN-1:0] r_inst, w_inst_nxt;
    logic            r_err, w_err_nxt;
    logic            r_req_valid, w_req_valid_nxt;
    logic            r_out_valid, w_out_valid_nxt;

    // State register; valids are registered from the next state so neither depends on a same-cycle input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_inst      <= NOP_INST;
            r_err       <= 1'b0;
            r_req_valid <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_inst      <= w_inst_nxt;
            r_err       <= w_err_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state logic; inputs not relevant to the current state are ignored.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_inst_nxt      = r_inst;
        w_err_nxt       = r_err;
        w_req_valid_nxt = 1'b0;
        w_out_valid_nxt = 1'b0;
        case (r_state)
            S_REQ: begin
                if (r_req_valid && mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERR;
                    end else begin
                        w_inst_nxt  = mem_rsp_data;
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit_valid) begin
                    // Misaligned targets still land in pc so the faulting address is observable.
                    w_pc_nxt = commit_dnpc;
                    if (commit_dnpc[1:0] != 2'b00) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_ERR: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_ERR;
            end
        endcase
        w_req_valid_nxt = (w_state_nxt == S_REQ);
        w_out_valid_nxt = (w_state_nxt == S_OUT);
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_pc;
    assign out_valid     = r_out_valid;
    assign out_inst      = r_inst;
    assign out_pc        = r_pc;
    assign fetch_err     = r_err;

`ifdef YSYX_23060096_IFU_PERF_EN
    logic        w_fetch_ok;
    logic        w_wait_cyc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_wait_cnt;

    assign w_fetch_ok = (r_state == S_WAIT) && mem_rsp_valid && !mem_rsp_err;
    assign w_wait_cyc = ((r_state == S_REQ) && !mem_req_ready) ||
                        ((r_state == S_WAIT) && !mem_rsp_valid);

    // Saturating event counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_cnt <= 32'd0;
            r_wait_cnt  <= 32'd0;
        end else begin
            if (w_fetch_ok && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_wait_cyc && (r_wait_cnt != 32'hFFFF_FFFF)) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_wait_cnt  = r_wait_cnt;
`else
    // Counters absent; the fetch path is unchanged.
`endif

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Scoreboard bench for ysyx_23060096_ifu: directed fetch/commit sequences, queued expectations checked by a monitor.
module tb_ysyx_23060096_ifu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        commit_valid;
    logic [31:0] commit_dnpc;
    logic        fetch_err;
`ifdef YSYX_23060096_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] q_addr[$];
    logic [63:0] q_out[$];

    always #5 clk = ~clk;

    ysyx_23060096_ifu dut (
        .clk           (clk),
        .rstn          (rstn),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .commit_valid  (commit_valid),
        .commit_dnpc   (commit_dnpc),
        .fetch_err     (fetch_err)
`ifdef YSYX_23060096_IFU_PERF_EN
       ,.perf_fetch_cnt(perf_fetch_cnt),
        .perf_wait_cnt (perf_wait_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake the DUT offers must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [63:0] eo;
        if (rstn === 1'b1) begin
            if (mem_req_valid && mem_req_ready) begin
                if (q_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", mem_req_addr);
                end else begin
                    ea = q_addr.pop_front();
                    chk("req_addr", mem_req_addr, ea);
                end
            end
            if (out_valid && out_ready) begin
                if (q_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got inst %h pc %h expected none", out_inst, out_pc);
                end else begin
                    eo = q_out.pop_front();
                    chk("out_inst", out_inst, eo[63:32]);
                    chk("out_pc", out_pc, eo[31:0]);
                end
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req_valid) chk("req_timeout", 32'(mem_req_valid), 32'd1);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) chk("out_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic accept_req(input logic [31:0] addr);
        wait_req();
        q_addr.push_back(addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err, input int dly);
        repeat (dly) tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    task automatic take_out();
        wait_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic commit(input logic [31:0] dnpc);
        commit_valid = 1'b1;
        commit_dnpc  = dnpc;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int dly);
        accept_req(addr);
        q_out.push_back({data, addr});
        respond(data, 1'b0, dly);
        take_out();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0000_0013);
        chk("rst_addr", mem_req_addr, 32'h8000_0000);
`ifdef YSYX_23060096_IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_wait", perf_wait_cnt, 32'd0);
`endif
        rstn = 1'b1;
    endtask

    task automatic check_halted(input string tag);
        mem_req_ready = 1'b1;
        repeat (4) begin
            tick();
            chk({tag, "_err"}, 32'(fetch_err), 32'd1);
            chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
            chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        end
        mem_req_ready = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        out_ready     = 1'b0;
        commit_valid  = 1'b0;
        commit_dnpc   = 32'h0;
        #1;
        do_reset();

        // Request held while memory is not ready.
        wait_req();
        repeat (3) begin
            chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_addr", mem_req_addr, 32'h8000_0000);
            tick();
        end
        accept_req(32'h8000_0000);
        q_out.push_back({32'h0050_0093, 32'h8000_0000});
        respond(32'h0050_0093, 1'b0, 0);

        // Decode stalls; a commit pulse meanwhile must be ignored.
        wait_out();
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_inst", out_inst, 32'h0050_0093);
            chk("hold_out_pc", out_pc, 32'h8000_0000);
            if (i == 2) begin
                commit_valid = 1'b1;
                commit_dnpc  = 32'h8000_0040;
            end
            tick();
            commit_valid = 1'b0;
        end
        out_ready    = 1'b1;
        commit_valid = 1'b1;
        commit_dnpc  = 32'h8000_0080;
        tick();
        out_ready    = 1'b0;
        commit_valid = 1'b0;
        repeat (3) begin
            chk("exec_out_valid", 32'(out_valid), 32'd0);
            chk("exec_req_valid", 32'(mem_req_valid), 32'd0);
            tick();
        end

        // Jump target, then wrap from the top of the address space.
        commit(32'h8000_0010);
        chk("jump_addr", mem_req_addr, 32'h8000_0010);
        fetch(32'h8000_0010, 32'h0000_8067, 2);
        commit(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0040_0113, 1);
        commit(32'h0000_0000);
        fetch(32'h0000_0000, 32'hFFF1_0193, 0);

        // Misaligned next PC halts the unit.
        commit(32'h8000_0002);
        check_halted("misalign");

        // Bus error on a fetch halts the unit.
        do_reset();
        accept_req(32'h8000_0000);
        respond(32'hDEAD_BEEF, 1'b1, 1);
        check_halted("bus_err");

        // Reset during a pending fetch; the late response must be ignored.
        do_reset();
        accept_req(32'h8000_0000);
        do_reset();
        respond(32'hBAD0_0BAD, 1'b0, 0);
        repeat (2) begin
            chk("stale_out_valid", 32'(out_valid), 32'd0);
            chk("stale_addr", mem_req_addr, 32'h8000_0000);
            tick();
        end
        fetch(32'h8000_0000, 32'h0010_0073, 1);
        commit(32'h8000_0004);
        wait_req();
        chk("seq_addr", mem_req_addr, 32'h8000_0004);

        repeat (2) tick();
        chk("addr_q_drained", 32'(q_addr.size()), 32'd0);
        chk("out_q_drained", 32'(q_out.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
